// File: rtl/sal_axi_ar_splitter.sv
// AXI AR burst splitter: cuts INCR bursts into MAX_BEATS / BOUNDARY-bounded sub-bursts and merges
// the R responses back by suppressing intermediate RLASTs. Optional stats: SAL_AR_SPLIT_STAT_EN.
module sal_axi_ar_splitter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned MAX_BEATS = 8,
  parameter int unsigned BOUNDARY  = 2048,
  parameter int unsigned TRK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              err_o
`ifdef SAL_AR_SPLIT_STAT_EN
  ,
  output logic [15:0]       stat_in_cnt_o,
  output logic [15:0]       stat_out_cnt_o
`endif
);

  localparam int unsigned BeatBytes = DATA_W / 8;
  localparam int unsigned BeatShift = $clog2(BeatBytes);
  localparam int unsigned BndBits   = $clog2(BOUNDARY);
  localparam int unsigned PtrW      = (TRK_DEPTH > 1) ? $clog2(TRK_DEPTH) : 1;
  localparam int unsigned CntW      = $clog2(TRK_DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StSplit} state_e;

  // Beats until the next boundary, limited by remaining beats and MAX_BEATS.
  function automatic logic [8:0] calc_chunk(input logic [ADDR_W-1:0] a, input logic [8:0] r);
    logic [31:0] off, room, c;
    off  = 32'(a[BndBits-1:0]);
    room = (BOUNDARY - off) / BeatBytes;
    c    = {23'd0, r};
    if (c > MAX_BEATS) c = MAX_BEATS;
    if (c > room) c = room;
    return c[8:0];
  endfunction

  state_e              state_q, state_d;
  logic                arready_q, arready_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [8:0]          rem_q, rem_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [TRK_DEPTH-1:0] trk_last_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                full_q, err_q;

  logic              s_hs, ar_hs, r_hs, push, pop, empty, is_last;
  logic [8:0]        chunk_cur, s_rem, next_rem;
  logic [ADDR_W-1:0] next_addr;

  assign s_hs      = s_arvalid & arready_q;
  assign ar_hs     = m_arvalid & m_arready;
  assign r_hs      = m_rvalid & s_rready;
  assign empty     = (cnt_q == '0);
  assign push      = ar_hs;
  assign pop       = r_hs & m_rlast & ~empty;
  assign chunk_cur = {1'b0, arlen_q} + 9'd1;
  assign is_last   = (rem_q == chunk_cur);
  assign s_rem     = {1'b0, s_arlen} + 9'd1;
  assign next_rem  = rem_q - chunk_cur;
  assign next_addr = addr_q + (ADDR_W'(chunk_cur) << BeatShift);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    arlen_d = arlen_q;
    unique case (state_q)
      StIdle: begin
        if (s_hs) begin
          id_d    = s_arid;
          addr_d  = s_araddr;
          rem_d   = s_rem;
          arlen_d = 8'(calc_chunk(s_araddr, s_rem) - 9'd1);
          state_d = StSplit;
        end
      end
      StSplit: begin
        if (ar_hs) begin
          addr_d = next_addr;
          rem_d  = next_rem;
          if (is_last) state_d = StIdle;
          else arlen_d = 8'(calc_chunk(next_addr, next_rem) - 9'd1);
        end
      end
    endcase
    arready_d = (state_d == StIdle);
    cnt_d     = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      arready_q  <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      arlen_q    <= '0;
      trk_last_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      arlen_q   <= arlen_d;
      if (push) begin
        trk_last_q[wr_ptr_q] <= is_last;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CntW'(TRK_DEPTH));
      if (r_hs && empty) err_q <= 1'b1;
    end
  end

  // Full flag is registered, so a same-cycle pop only re-enables issue on the next cycle.
  assign s_arready = arready_q;
  assign m_arvalid = (state_q == StSplit) && !full_q;
  assign m_arid    = id_q;
  assign m_araddr  = addr_q;
  assign m_arlen   = arlen_q;

  assign s_rvalid = m_rvalid;
  assign m_rready = s_rready;
  assign s_rid    = m_rid;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast & (empty | trk_last_q[rd_ptr_q]);
  assign err_o    = err_q;

`ifdef SAL_AR_SPLIT_STAT_EN
  logic [15:0] in_cnt_q, out_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (s_hs && in_cnt_q != 16'hFFFF) in_cnt_q <= in_cnt_q + 16'd1;
      if (ar_hs && out_cnt_q != 16'hFFFF) out_cnt_q <= out_cnt_q + 16'd1;
    end
  end
  assign stat_in_cnt_o  = in_cnt_q;
  assign stat_out_cnt_o = out_cnt_q;
`endif

endmodule

// File: tb/tb_sal_axi_ar_splitter.sv
// Directed bench for sal_axi_ar_splitter: scoreboard queues for expected AR sub-bursts and R beats.
module tb_sal_axi_ar_splitter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         s_arvalid = 0, s_arready;
  logic [3:0]   s_arid = 0;
  logic [31:0]  s_araddr = 0;
  logic [7:0]   s_arlen = 0;
  logic         m_arvalid, m_arready = 1;
  logic [3:0]   m_arid;
  logic [31:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic         m_rvalid = 0, m_rready;
  logic [3:0]   m_rid = 0;
  logic [127:0] m_rdata = 0;
  logic [1:0]   m_rresp = 0;
  logic         m_rlast = 0;
  logic         s_rvalid, s_rready = 1;
  logic [3:0]   s_rid;
  logic [127:0] s_rdata;
  logic [1:0]   s_rresp;
  logic         s_rlast;
  logic         err_o;
`ifdef SAL_AR_SPLIT_STAT_EN
  logic [15:0]  stat_in_cnt_o, stat_out_cnt_o;
`endif

  sal_axi_ar_splitter dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .err_o(err_o)
`ifdef SAL_AR_SPLIT_STAT_EN
    , .stat_in_cnt_o(stat_in_cnt_o), .stat_out_cnt_o(stat_out_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [7:0] len; logic [3:0] id;} ar_t;
  typedef struct {logic last; logic [127:0] data; logic [3:0] id;} r_t;
  ar_t ar_q[$];
  r_t  r_q[$];
  ar_t ae;
  r_t  re;
  int  total = 0;
  int  bad = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors sample mid-cycle; the handshake completes on the following posedge.
  always @(negedge clk) begin
    if (rst_n && m_arvalid && m_arready) begin
      if (ar_q.size() == 0) check("ar_unexpected", 128'(ar_q.size()), 128'd1);
      else begin
        ae = ar_q.pop_front();
        check("m_araddr", 128'(m_araddr), 128'(ae.addr));
        check("m_arlen", 128'(m_arlen), 128'(ae.len));
        check("m_arid", 128'(m_arid), 128'(ae.id));
      end
    end
    if (rst_n && s_rvalid && s_rready) begin
      if (r_q.size() == 0) check("r_unexpected", 128'(r_q.size()), 128'd1);
      else begin
        re = r_q.pop_front();
        check("s_rlast", 128'(s_rlast), 128'(re.last));
        check("s_rdata", s_rdata, re.data);
        check("s_rid", 128'(s_rid), 128'(re.id));
        check("s_rresp", 128'(s_rresp), 128'(re.data[1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic exp_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    ar_q.push_back('{addr, len, id});
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arvalid = 1'b1;
    while (!s_arready && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    check("ar_accept_timeout", 128'(n < 200), 128'd1);
  endtask

  task automatic wait_ar_drain();
    int n = 0;
    while (ar_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    check("ar_drain_timeout", 128'(ar_q.size()), 128'd0);
  endtask

  task automatic send_r(input logic [3:0] id, input logic [127:0] data, input logic last,
                        input logic exp_last);
    r_q.push_back('{exp_last, data, id});
    m_rvalid = 1'b1; m_rid = id; m_rdata = data; m_rresp = data[1:0]; m_rlast = last;
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_arready"}, 128'(s_arready), 128'd0);
    check({tag, "_m_arvalid"}, 128'(m_arvalid), 128'd0);
    check({tag, "_m_araddr"}, 128'(m_araddr), 128'd0);
    check({tag, "_m_arlen"}, 128'(m_arlen), 128'd0);
    check({tag, "_m_arid"}, 128'(m_arid), 128'd0);
    check({tag, "_err"}, 128'(err_o), 128'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 16 beats at 0x0 -> two 8-beat sub-bursts; only the 16th beat carries s_rlast.
    exp_ar(4'd3, 32'h0, 8'd7);
    exp_ar(4'd3, 32'h80, 8'd7);
    send_ar(4'd3, 32'h0, 8'd15);
    wait_ar_drain();
    for (int i = 0; i < 16; i++) send_r(4'd3, 128'(i + 1), (i == 7) || (i == 15), i == 15);

    // Row-boundary split at 0x800.
    exp_ar(4'd5, 32'h7C0, 8'd3);
    exp_ar(4'd5, 32'h800, 8'd3);
    send_ar(4'd5, 32'h7C0, 8'd7);
    wait_ar_drain();
    for (int i = 0; i < 8; i++) send_r(4'd5, 128'(32'hA0 + i), (i == 3) || (i == 7), i == 7);

    // Single-beat burst.
    exp_ar(4'd6, 32'h1230, 8'd0);
    send_ar(4'd6, 32'h1230, 8'd0);
    wait_ar_drain();
    send_r(4'd6, 128'h55, 1'b1, 1'b1);
    check("single_err", 128'(err_o), 128'd0);

    // Backpressure on m_arready: request must hold steady.
    m_arready = 1'b0;
    exp_ar(4'd1, 32'h2000, 8'd3);
    send_ar(4'd1, 32'h2000, 8'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_m_arvalid", 128'(m_arvalid), 128'd1);
      check("stall_m_araddr", 128'(m_araddr), 128'h2000);
      check("stall_m_arlen", 128'(m_arlen), 128'd3);
      check("stall_s_arready", 128'(s_arready), 128'd0);
    end
    @(posedge clk); #1 m_arready = 1'b1;
    wait_ar_drain();
    for (int i = 0; i < 4; i++) send_r(4'd1, 128'(32'hB0 + i), i == 3, i == 3);

    // Fill the tracker with R stalled; the 17th sub-burst waits for a pop.
    for (int i = 0; i < 16; i++) begin
      exp_ar(4'(i), 32'h3000 + 32'(i * 16), 8'd0);
      send_ar(4'(i), 32'h3000 + 32'(i * 16), 8'd0);
    end
    send_ar(4'd7, 32'h4000, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_m_arvalid", 128'(m_arvalid), 128'd0);
      check("full_s_arready", 128'(s_arready), 128'd0);
    end
    exp_ar(4'd7, 32'h4000, 8'd0);
    @(posedge clk); #1;
    r_q.push_back('{1'b1, 128'h300, 4'd0});
    m_rvalid = 1'b1; m_rid = 4'd0; m_rdata = 128'h300; m_rresp = 2'b00; m_rlast = 1'b1;
    @(negedge clk);
    check("pop_cycle_m_arvalid", 128'(m_arvalid), 128'd0);
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    @(negedge clk);
    check("after_pop_m_arvalid", 128'(m_arvalid), 128'd1);
    @(posedge clk); #1;
    wait_ar_drain();
    for (int i = 1; i < 17; i++) send_r(4'(i), 128'(32'h300 + i * 4), 1'b1, 1'b1);
    check("fill_err", 128'(err_o), 128'd0);

    // Reset mid-SPLIT, then a stray R beat flags an error.
    m_arready = 1'b0;
    send_ar(4'd2, 32'h0, 8'd15);
    @(negedge clk);
    check("presplit_m_arvalid", 128'(m_arvalid), 128'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge clk); #1 rst_n = 1'b1; m_arready = 1'b1;
    repeat (2) @(posedge clk);
    #1 send_r(4'd9, 128'hEE, 1'b1, 1'b1);
    @(negedge clk);
    check("stray_err", 128'(err_o), 128'd1);
    repeat (3) @(posedge clk);
    #1 check("sticky_err", 128'(err_o), 128'd1);
    check("idle_m_arvalid", 128'(m_arvalid), 128'd0);

    check("ar_q_empty", 128'(ar_q.size()), 128'd0);
    check("r_q_empty", 128'(r_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sal_axi_ar_splitter.md
Name: sal_axi_ar_splitter

Overview:
- AXI read-address burst splitter placed directly upstream of the DDR controller's AR input.
- Cuts each incoming INCR read burst into sub-bursts of at most MAX_BEATS beats. No sub-burst crosses a BOUNDARY-byte (DRAM row) boundary.
- On the R path it merges the sub-burst responses back into one burst by suppressing every RLAST except the final one.
- A per-sub-burst tracking FIFO links the AR side to the R side.

Parameters:
- ADDR_W, 32, AXI address width.
- ID_W, 4, AXI ID width.
- DATA_W, 128, R data width. BEAT_BYTES = DATA_W/8.
- MAX_BEATS, 8, maximum beats per sub-burst. Power of two, 1..256.
- BOUNDARY, 2048, split boundary in bytes. Power of two, >= MAX_BEATS*BEAT_BYTES.
- TRK_DEPTH, 16, tracking FIFO entries. Power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- s_arvalid  in  1  upstream AR valid
- s_arready  out  1  upstream AR ready
- s_arid  in  ID_W  upstream AR ID
- s_araddr  in  ADDR_W  upstream AR address, BEAT_BYTES-aligned
- s_arlen  in  8  upstream AR length (beats-1)
- m_arvalid  out  1  controller AR valid
- m_arready  in  1  controller AR ready
- m_arid  out  ID_W  controller AR ID
- m_araddr  out  ADDR_W  controller AR address
- m_arlen  out  8  controller AR length
- m_rvalid  in  1  controller R valid
- m_rready  out  1  controller R ready
- m_rid  in  ID_W  controller R ID
- m_rdata  in  DATA_W  controller R data
- m_rresp  in  2  controller R response
- m_rlast  in  1  controller R last
- s_rvalid  out  1  upstream R valid
- s_rready  in  1  upstream R ready
- s_rid  out  ID_W  upstream R ID
- s_rdata  out  DATA_W  upstream R data
- s_rresp  out  2  upstream R response
- s_rlast  out  1  upstream R last
- err_o  out  1  sticky protocol error

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: FSM=IDLE, s_arready=0, m_arvalid=0, m_araddr/m_arid/m_arlen=0, tracker empty, err_o=0.
- FSM states are IDLE and SPLIT.
- IDLE:
  - s_arready = 1.
  - On s_arvalid&s_arready, register id, addr and rem = s_arlen+1 (9-bit), then go to SPLIT.
  - Zero-cycle AR latency is not required; minimum latency is 1 cycle.
- SPLIT:
  - s_arready = 0.
  - chunk = min(rem, MAX_BEATS, (BOUNDARY - addr%BOUNDARY)/BEAT_BYTES).
  - m_araddr = addr, m_arlen = chunk-1, m_arid = id.
  - m_arvalid asserts only when the tracker is not full (registered full flag). Once asserted, all m_ar* fields stay stable until m_arready; only this path pushes, so the tracker cannot fill meanwhile.
- On m_arvalid&m_arready:
  - Push one tracker entry, is_last = (rem==chunk).
  - Update addr += chunk*BEAT_BYTES (wraps mod 2^ADDR_W) and rem -= chunk.
  - If is_last, return to IDLE. The next s_ar may be accepted in the following cycle.
- R path is combinational pass-through:
  - s_rvalid=m_rvalid, m_rready=s_rready.
  - s_rid, s_rdata and s_rresp are copied from m_*.
  - s_rlast = m_rlast & tracker_head.is_last.
  - Pop the tracker on m_rvalid&m_rready&m_rlast.
- Ordering: the controller returns sub-bursts in AR issue order; the tracker relies on this.
- Tracker pop and push in the same cycle are both allowed. If the tracker was full at the start of that cycle, m_arvalid stays 0 that cycle and asserts the next.
- Error: an R beat while the tracker is empty sets err_o (sticky until reset). Data still passes through with s_rlast=m_rlast.
- Reset asserted mid-SPLIT: immediate return to reset values. The tracker is cleared, and in-flight sub-bursts are lost.

Optional Feature:
- Macro: SAL_AR_SPLIT_STAT_EN.
- When defined, adds two outputs:
  - stat_in_cnt_o [15:0]: count of accepted s_ar transactions.
  - stat_out_cnt_o [15:0]: count of issued m_ar sub-bursts.
  - Both are saturating at 0xFFFF and reset to 0.
- When undefined, these ports and counters do not exist.

Test Plan:
- s_araddr=0x0, s_arlen=15, MAX_BEATS=8, DATA_W=128 -> m_ar (0x000,len7) then (0x080,len7). s_rlast only on the 16th beat.
- s_araddr=0x7C0, s_arlen=7, BOUNDARY=2048 -> m_ar (0x7C0,len3) then (0x800,len3). The first m_rlast is suppressed and the second is forwarded.
- s_arlen=0 at 0x1230 -> a single m_ar (0x1230,len0). The single R beat has s_rlast=1 and the tracker is empty afterwards.
- m_arready held 0 for 5 cycles -> m_arvalid stays high with m_araddr/m_arlen unchanged, s_arready=0 throughout.
- Issue 16 single-beat reads with R stalled (TRK_DEPTH=16) -> the 17th m_arvalid stays 0. After one R beat with rlast pops an entry, the 17th m_arvalid asserts in the following cycle.
- Assert rst_n=0 mid-SPLIT -> all outputs return to reset values immediately. An R beat then arriving with the tracker empty sets err_o=1.
